// File: rtl/cache_mem_responder.sv
// Main-memory responder for cache refills and write-backs.
// Fixed-latency block access over a byte-addressed store.
module cache_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int BLOCK_BYTES = 16,
    parameter int LATENCY     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rw,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [8*BLOCK_BYTES-1:0] req_wblock,
    output logic                     resp_valid,
    output logic [8*BLOCK_BYTES-1:0] resp_rblock
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BW    = 8 * BLOCK_BYTES;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [BW-1:0]         wdata_q, wdata_d;
    logic [BW-1:0]         rblock_q, rblock_d;
    logic [BW-1:0]         rd_block;
    logic                  mem_we;
    logic [7:0]            memory [DEPTH];

    always_comb begin
        rd_block = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            rd_block[8*i +: 8] = memory[base_q + ADDR_WIDTH'(i)];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        rblock_d   = rblock_q;
        mem_we     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    rw_d    = req_rw;
                    base_d  = req_addr & ~ADDR_WIDTH'(BLOCK_BYTES - 1);
                    wdata_d = req_wblock;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Write commits here so a following read sees it
                    mem_we   = rw_q;
                    rblock_d = rw_q ? wdata_q : rd_block;
                    state_d  = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_rblock = rblock_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rw_q     <= 1'b0;
            base_q   <= '0;
            wdata_q  <= '0;
            rblock_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rw_q     <= rw_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            rblock_q <= rblock_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                memory[j] <= 8'h00;
            end
        end else if (mem_we) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                memory[base_q + ADDR_WIDTH'(i)] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized bench for cache_mem_responder against a byte-array model.
// Model tracks memory contents and the expected response per request.
module tb_cache_mem_responder;

    localparam int AW  = 10;
    localparam int BB  = 16;
    localparam int LAT = 4;
    localparam int MEM = 2 ** AW;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_rw = 1'b0;
    logic [AW-1:0]  req_addr = '0;
    logic [127:0]   req_wblock = '0;
    logic           resp_valid;
    logic [127:0]   resp_rblock;

    logic [7:0] ref_mem [MEM];
    int n_cmp = 0;
    int n_bad = 0;

    cache_mem_responder #(
        .ADDR_WIDTH(AW),
        .BLOCK_BYTES(BB),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rw(req_rw),
        .req_addr(req_addr),
        .req_wblock(req_wblock),
        .resp_valid(resp_valid),
        .resp_rblock(resp_rblock)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] model_read(input logic [AW-1:0] a);
        int base;
        logic [127:0] r;
        base = (int'(a) / BB) * BB;
        for (int i = 0; i < BB; i++) r[8*i +: 8] = ref_mem[base + i];
        return r;
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [127:0] d);
        int base;
        base = (int'(a) / BB) * BB;
        for (int i = 0; i < BB; i++) ref_mem[base + i] = d[8*i +: 8];
    endfunction

    function automatic int mem_diffs();
        int d;
        d = 0;
        for (int i = 0; i < MEM; i++) if (dut.memory[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    // Drives one request held for one cycle, scrambles fields afterwards,
    // and reports latency, returned block and handshake sanity.
    task automatic txn(input logic rw, input logic [AW-1:0] a, input logic [127:0] wb,
                       output logic [127:0] rb, output int lat, output bit hs_ok);
        hs_ok = 1'b1;
        lat   = -1;
        rb    = 'x;
        @(negedge clk);
        if (req_ready !== 1'b1) hs_ok = 1'b0;
        req_valid  = 1'b1;
        req_rw     = rw;
        req_addr   = a;
        req_wblock = wb;
        @(negedge clk);
        req_valid  = 1'b0;
        req_rw     = 1'($urandom);
        req_addr   = AW'($urandom);
        req_wblock = {$urandom, $urandom, $urandom, $urandom};
        if (req_ready !== 1'b0 || resp_valid !== 1'b0) hs_ok = 1'b0;
        for (int n = 1; n <= LAT + 8; n++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                lat = n;
                rb  = resp_rblock;
                break;
            end
            if (req_ready !== 1'b0) hs_ok = 1'b0;
        end
        if (lat > 0) begin
            if (req_ready !== 1'b0) hs_ok = 1'b0;
            @(negedge clk);
            if (req_ready !== 1'b1 || resp_valid !== 1'b0) hs_ok = 1'b0;
            if (resp_rblock !== rb) hs_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        for (int i = 0; i < MEM; i++) ref_mem[i] = 8'h00;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got=%b want=1", req_ready);
        end
        n_cmp++;
        if (resp_valid !== 1'b0 || resp_rblock !== 128'h0) begin
            n_bad++;
            $display("FAIL reset_resp got=%b/%h want=0/0", resp_valid, resp_rblock);
        end
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (mem_diffs() != 0) begin
            n_bad++;
            $display("FAIL reset_mem got=%0d diffs want=0", mem_diffs());
        end
    endtask

    task automatic test_read_zero();
        logic [127:0] rb;
        int lat;
        bit ok;
        txn(1'b0, 10'h000, 128'h0, rb, lat, ok);
        n_cmp++;
        if (lat !== LAT || !ok) begin
            n_bad++;
            $display("FAIL read0_timing got lat=%0d hs=%0b want lat=%0d hs=1", lat, ok, LAT);
        end
        n_cmp++;
        if (rb !== 128'h0) begin
            n_bad++;
            $display("FAIL read0_data got=%h want=0", rb);
        end
    endtask

    task automatic test_write_read();
        logic [127:0] rb;
        logic [127:0] wd;
        int lat;
        bit ok;
        wd = 128'h000000FF_00000000_00000000_000000FF;
        txn(1'b1, 10'h200, wd, rb, lat, ok);
        model_write(10'h200, wd);
        n_cmp++;
        if (lat !== LAT || !ok || rb !== wd) begin
            n_bad++;
            $display("FAIL wr200_resp got lat=%0d hs=%0b rb=%h want lat=%0d hs=1 rb=%h",
                     lat, ok, rb, LAT, wd);
        end
        n_cmp++;
        if (dut.memory[10'h200] !== 8'hFF || dut.memory[10'h20C] !== 8'hFF) begin
            n_bad++;
            $display("FAIL wr200_bytes got=%h/%h want=ff/ff",
                     dut.memory[10'h200], dut.memory[10'h20C]);
        end
        n_cmp++;
        if (mem_diffs() != 0) begin
            n_bad++;
            $display("FAIL wr200_mem got=%0d diffs want=0", mem_diffs());
        end
        txn(1'b0, 10'h207, 128'h0, rb, lat, ok);
        n_cmp++;
        if (rb !== model_read(10'h207) || lat !== LAT) begin
            n_bad++;
            $display("FAIL rd207 got=%h lat=%0d want=%h lat=%0d", rb, lat, model_read(10'h207), LAT);
        end
    endtask

    task automatic test_write_other_read();
        logic [127:0] rb;
        logic [127:0] wd;
        int lat;
        bit ok;
        wd = {$urandom, $urandom, $urandom, $urandom};
        txn(1'b1, 10'h000, wd, rb, lat, ok);
        model_write(10'h000, wd);
        txn(1'b0, 10'h300, 128'h0, rb, lat, ok);
        n_cmp++;
        if (rb !== 128'h0 || !ok) begin
            n_bad++;
            $display("FAIL rd300 got=%h hs=%0b want=0 hs=1", rb, ok);
        end
        n_cmp++;
        if (mem_diffs() != 0) begin
            n_bad++;
            $display("FAIL rd300_mem got=%0d diffs want=0", mem_diffs());
        end
    endtask

    task automatic test_field_change();
        logic [127:0] rb;
        logic [127:0] wd;
        int lat;
        bit ok;
        wd = {$urandom, $urandom, $urandom, $urandom};
        txn(1'b1, 10'h040, wd, rb, lat, ok);
        model_write(10'h040, wd);
        n_cmp++;
        if (mem_diffs() != 0 || model_read(10'h040) !== wd) begin
            n_bad++;
            $display("FAIL field_change got=%0d diffs want=0", mem_diffs());
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        logic [127:0] expq[$];
        logic [127:0] e;
        int cyc;
        int got;
        bit sw;
        int bad_gap;
        logic [127:0] rb;
        int lat;
        bit ok;
        txn(1'b1, 10'h000, {4{$urandom}}, rb, lat, ok);
        model_write(10'h000, rb);
        txn(1'b1, 10'h100, {4{$urandom}}, rb, lat, ok);
        model_write(10'h100, rb);
        got = 0;
        cyc = 0;
        sw  = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 10'h000;
        while (cyc < 80 && (acc.size() < 4 || expq.size() != 0)) begin
            if (sw) begin
                req_addr = (req_addr == 10'h000) ? 10'h100 : 10'h000;
                sw = 1'b0;
                if (acc.size() == 4) req_valid = 1'b0;
            end
            if (resp_valid === 1'b1) begin
                got++;
                e = (expq.size() != 0) ? expq.pop_front() : 'x;
                n_cmp++;
                if (resp_rblock !== e) begin
                    n_bad++;
                    $display("FAIL b2b_data got=%h want=%h", resp_rblock, e);
                end
            end
            if (req_valid && req_ready === 1'b1) begin
                acc.push_back(cyc);
                expq.push_back(model_read(req_addr));
                sw = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        bad_gap = 0;
        for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != LAT + 2) bad_gap++;
        n_cmp++;
        if (acc.size() != 4 || got != 4 || bad_gap != 0) begin
            n_bad++;
            $display("FAIL b2b_accept got acc=%0d resp=%0d badgap=%0d want 4/4/0",
                     acc.size(), got, bad_gap);
        end
    endtask

    task automatic test_random();
        logic [127:0] rb;
        logic [127:0] wd;
        logic [127:0] e;
        logic [AW-1:0] a;
        logic rw;
        int lat;
        bit ok;
        int bad;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            rw = 1'($urandom);
            a  = AW'($urandom_range(0, 15) * 64 + $urandom_range(0, 63));
            wd = {$urandom, $urandom, $urandom, $urandom};
            e  = rw ? wd : model_read(a);
            txn(rw, a, wd, rb, lat, ok);
            if (rw) model_write(a, wd);
            n_cmp++;
            if (rb !== e || lat !== LAT || !ok) begin
                n_bad++;
                bad++;
                $display("FAIL rand_%0d rw=%0b a=%h got=%h lat=%0d hs=%0b want=%h lat=%0d",
                         k, rw, a, rb, lat, ok, e, LAT);
            end
        end
        n_cmp++;
        if (mem_diffs() != 0) begin
            n_bad++;
            $display("FAIL rand_mem got=%0d diffs want=0", mem_diffs());
        end
    endtask

    task automatic test_reset_midop();
        int seen;
        @(negedge clk);
        req_valid  = 1'b1;
        req_rw     = 1'b1;
        req_addr   = 10'h080;
        req_wblock = {4{32'hA5A5_5A5A}};
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        for (int i = 0; i < MEM; i++) ref_mem[i] = 8'h00;
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_state got rdy=%b rv=%b want 1/0", req_ready, resp_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0 || dut.memory[10'h080] !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_commit got resp=%0d mem=%h want 0/00", seen, dut.memory[10'h080]);
        end
        n_cmp++;
        if (mem_diffs() != 0) begin
            n_bad++;
            $display("FAIL midrst_mem got=%0d diffs want=0", mem_diffs());
        end
    endtask

    initial begin
        test_reset();
        test_read_zero();
        test_write_read();
        test_write_other_read();
        test_field_change();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Main-memory side of the cache/memory refill interface.
- Services block reads (refills) and block writes (write-backs) issued by the cache controller.
- Backing store is a byte-addressed memory with a fixed access latency and a valid/ready request handshake.
- Sits between the cache block and nothing else; it is the final level of the memory hierarchy in the 10-bit-address system.

Parameters:
- ADDR_WIDTH, 10, byte-address width; memory holds 2**ADDR_WIDTH bytes.
- BLOCK_BYTES, 16, bytes per cache block (4 words of 32 bits); must be a power of 2.
- LATENCY, 4, cycles from request acceptance to response; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  cache presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_rw  input  1  0 = block read (refill), 1 = block write (write-back).
- req_addr  input  ADDR_WIDTH  byte address; low log2(BLOCK_BYTES) bits ignored (block-aligned).
- req_wblock  input  8*BLOCK_BYTES  write-back block data.
- resp_valid  output  1  one-cycle pulse: access complete.
- resp_rblock  output  8*BLOCK_BYTES  block data for the completed access.

Behaviour:
- Storage: byte array named memory, depth 2**ADDR_WIDTH, 8 bits wide. Benches inspect it hierarchically.
- Byte lane i of a block (bits 8i+7:8i) maps to memory[base+i], where base = req_addr with its low offset bits cleared.
- Reset (asynchronous, any state): FSM -> IDLE; counter = 0; all memory bytes = 0x00; req_ready = 1; resp_valid = 0; resp_rblock = 0.
- Reset mid-operation: the request is abandoned, no write is committed and no response is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid = 1: latch req_rw, the aligned base and req_wblock; load counter = LATENCY-1; go to WAIT.
- WAIT:
  - req_ready = 0.
  - Each edge with counter != 0: decrement counter.
  - Edge with counter == 0:
    - Write: commit all BLOCK_BYTES bytes to memory and set resp_rblock = the latched write data.
    - Read: set resp_rblock = memory[base..base+BLOCK_BYTES-1].
    - Go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle; req_ready = 0.
  - Next edge: go to IDLE.
  - resp_rblock holds its value until the next completed access or reset.
- Latency: the acceptance edge is edge 0. resp_valid is high between edge LATENCY and edge LATENCY+1. The next request can be accepted at edge LATENCY+2 at the earliest.
  - With LATENCY=4, one transaction occupies 6 cycles.
  - With LATENCY=1, the access commits at edge 1.
- req_valid while req_ready = 0 is ignored. The requester holds req_valid and its fields until it sees a handshake.
- Request fields are sampled only at acceptance; changes during WAIT or RESP have no effect.
- Read issued right after a write to the same block returns the new data, because the write commits before RESP.
- No ready signal on the response: the cache always accepts resp_valid.
- No address is out of range: the ADDR_WIDTH address covers the full memory.

Test Plan:
- Reset, then read req_addr=0x000 held for one cycle -> req_ready drops at edge 0; resp_valid pulses between edges 4 and 5; resp_rblock = 128'h0.
- Write req_addr=0x200, req_wblock = 128'h000000FF_00000000_00000000_000000FF -> after the response, memory[0x200] = 0xFF, memory[0x20C] = 0xFF, all other bytes 0x00. Then read 0x207 -> resp_rblock equals that block.
- Write 0x000, then read 0x300 -> memory[0x000..0x00F] unchanged by the read; resp_rblock = 0.
- Hold req_valid continuously with alternating addresses 0x000 and 0x100 -> exactly one acceptance every 6 cycles; no request is dropped or duplicated; req_ready = 0 throughout WAIT and RESP.
- Change req_addr and req_wblock during WAIT of a write to 0x040 -> only the originally latched data is written, to 0x040.
- Assert reset one cycle before commit of a write to 0x080 -> no resp_valid; memory[0x080] = 0x00; req_ready = 1 immediately.
